// File: rtl/regfile_mp.sv
// regfile_mp: two registered read ports, one write port, storage cleared by a post-reset init sequencer.
// Optional macro REGFILE_BYPASS_EN: same-edge write-to-read bypass (write-first); default is read-first.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] IDX_STEP  = {{ADDR_W{1'b0}}, 1'b1};

  localparam logic STATE_INIT = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  logic              state;
  // One bit wider than the address so the counter can reach DEPTH without wrapping.
  logic [ADDR_W:0]   init_idx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              run;
  logic              wr_commit;
  logic [DATA_W-1:0] rd_next1;
  logic [DATA_W-1:0] rd_next2;

  function automatic logic addr_live(input logic [ADDR_W-1:0] addr);
    logic in_range;
    logic zero_hit;
    in_range = ({1'b0, addr} < DEPTH_LIM);
    zero_hit = (ZERO_REG != 0) && (addr == '0);
    return in_range && !zero_hit;
  endfunction

  assign run       = (state == STATE_RUN);
  assign ready     = run;
  assign wr_commit = run && wr_en && addr_live(wr_addr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= STATE_INIT;
      init_idx <= '0;
    end else if (state == STATE_INIT) begin
      init_idx <= init_idx + IDX_STEP;
      if (init_idx == LAST_IDX) begin
        state <= STATE_RUN;
      end
    end
  end

  // Storage: cleared one entry per cycle during INIT; a reset edge discards the write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == STATE_INIT) begin
        mem[init_idx[IDX_W-1:0]] <= '0;
      end else if (wr_commit) begin
        mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_next1 = '0;
    rd_next2 = '0;
    if (addr_live(rd_addr1)) begin
      rd_next1 = mem[rd_addr1[IDX_W-1:0]];
    end
    if (addr_live(rd_addr2)) begin
      rd_next2 = mem[rd_addr2[IDX_W-1:0]];
    end
`ifdef REGFILE_BYPASS_EN
    // wr_commit already excludes dropped writes, so zero/out-of-range rules still win.
    if (wr_commit && (rd_addr1 == wr_addr)) begin
      rd_next1 = wr_data;
    end
    if (wr_commit && (rd_addr2 == wr_addr)) begin
      rd_next2 = wr_data;
    end
`endif
  end

  // Read stage: outputs load only in RUN with rd_en, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n || (state == STATE_INIT)) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else if (rd_en) begin
      rd_data1 <= rd_next1;
      rd_data2 <= rd_next2;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: two instances (DEPTH=32/ZERO_REG=1 and DEPTH=16/ZERO_REG=0) share stimulus
// and are checked every cycle against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NI = 2;

`ifdef REGFILE_BYPASS_EN
  localparam logic [DW-1:0] EXP_BYP = 32'h12345678;
`else
  localparam logic [DW-1:0] EXP_BYP = 32'h11111111;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_en;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic          ready_a, ready_b;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_a), .rd_data2(rd2_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ready(ready_a)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(16), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd1_b), .rd_data2(rd2_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ready(ready_b)
  );

  // Reference model state, one slot per instance
  logic [DW-1:0] m_mem [NI][32];
  int            m_cnt [NI];
  bit            m_ready [NI];
  logic [DW-1:0] m_rd1 [NI];
  logic [DW-1:0] m_rd2 [NI];

  int n_cmp = 0;
  int n_err = 0;

  function automatic int m_depth(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic bit m_zero(input int i);
    return (i == 0);
  endfunction

  function automatic logic [DW-1:0] m_val(input int i, input logic [AW-1:0] a, input bit wr_live);
    if (int'(a) >= m_depth(i)) return '0;
    if (m_zero(i) && a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_live && a == wr_addr) return wr_data;
`endif
    return m_mem[i][a];
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_cnt[i]   = 0;
        m_ready[i] = 1'b0;
        m_rd1[i]   = '0;
        m_rd2[i]   = '0;
      end else if (!m_ready[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == m_depth(i)) begin
          m_ready[i] = 1'b1;
          for (int a = 0; a < 32; a++) m_mem[i][a] = '0;
        end
      end else begin
        bit wr_live;
        wr_live = wr_en && (int'(wr_addr) < m_depth(i)) && !(m_zero(i) && wr_addr == '0);
        if (rd_en) begin
          m_rd1[i] = m_val(i, rd_addr1, wr_live);
          m_rd2[i] = m_val(i, rd_addr2, wr_live);
        end
        if (wr_live) m_mem[i][wr_addr] = wr_data;
      end
    end
  endtask

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("ready_a", 32'(ready_a), 32'(m_ready[0]));
    check("rd1_a",   rd1_a,        m_rd1[0]);
    check("rd2_a",   rd2_a,        m_rd2[0]);
    check("ready_b", 32'(ready_b), 32'(m_ready[1]));
    check("rd1_b",   rd1_b,        m_rd1[1]);
    check("rd2_b",   rd2_b,        m_rd2[1]);
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    rd_en   = 1'b0;
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input int a1, input int a2);
    wr_en    = 1'b0;
    rd_en    = 1'b1;
    rd_addr1 = AW'(a1);
    rd_addr2 = AW'(a2);
    step();
    rd_en    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_ready[i] = 1'b0; m_rd1[i] = '0; m_rd2[i] = '0;
      for (int a = 0; a < 32; a++) m_mem[i][a] = '0;
    end

    step();
    step();
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_rd1_a", rd1_a, 32'h0);

    // Init phase: random enables must be ignored until each instance is ready
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      rd_en    = 1'($urandom_range(0, 1));
      wr_en    = 1'($urandom_range(0, 1));
      rd_addr1 = AW'($urandom_range(0, 31));
      rd_addr2 = AW'($urandom_range(0, 31));
      wr_addr  = AW'($urandom_range(0, 31));
      wr_data  = $urandom;
      step();
      if (k == 30) check("init_ready_low_a", 32'(ready_a), 32'd0);
    end
    check("init_ready_high_a", 32'(ready_a), 32'd1);
    wr_en = 1'b0; rd_en = 1'b0;

    for (int a = 0; a < 32; a++) begin
      do_read(a, 31 - a);
      check("clear_rd1_a", rd1_a, 32'h0);
      check("clear_rd2_a", rd2_a, 32'h0);
    end

    do_write(5, 32'hDEADBEEF);
    do_read(5, 5);
    check("wr_r5_rd1_a", rd1_a, 32'hDEADBEEF);
    check("wr_r5_rd2_a", rd2_a, 32'hDEADBEEF);
    rd_en = 1'b0; rd_addr1 = AW'(9); rd_addr2 = AW'(1);
    step();
    step();
    check("hold_rd1_a", rd1_a, 32'hDEADBEEF);
    check("hold_rd2_a", rd2_a, 32'hDEADBEEF);

    do_write(7, 32'h11111111);
    wr_en = 1'b1; wr_addr = AW'(7); wr_data = 32'h12345678;
    rd_en = 1'b1; rd_addr1 = AW'(7); rd_addr2 = AW'(7);
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    check("same_edge_r7_a", rd1_a, EXP_BYP);
    check("same_edge_r7_b", rd2_b, EXP_BYP);
    do_read(7, 7);
    check("after_r7_a", rd1_a, 32'h12345678);

    do_write(0, 32'hFFFFFFFF);
    do_read(0, 0);
    check("zero_reg_a", rd1_a, 32'h0);
    check("plain_r0_b", rd1_b, 32'hFFFFFFFF);

    do_write(4, 32'h44444444);
    do_write(20, 32'hA5A5A5A5);
    do_read(20, 4);
    check("oor_r20_b", rd1_b, 32'h0);
    check("oor_r4_b", rd2_b, 32'h44444444);
    check("inrange_r20_a", rd1_a, 32'hA5A5A5A5);

    do_write(3, 32'hCAFEF00D);
    do_read(3, 3);
    check("r3_before_rst_a", rd1_a, 32'hCAFEF00D);
    rst_n = 1'b0;
    wr_en = 1'b1; wr_addr = AW'(3); wr_data = 32'h0BADF00D;
    step();
    wr_en = 1'b0;
    check("midrst_ready_a", 32'(ready_a), 32'd0);
    check("midrst_rd1_a", rd1_a, 32'h0);
    rst_n = 1'b1;
    repeat (32) step();
    check("midrst_ready_back_a", 32'(ready_a), 32'd1);
    do_read(3, 3);
    check("midrst_r3_a", rd1_a, 32'h0);
    check("midrst_r3_b", rd2_b, 32'h0);

    // Random traffic with address collisions and occasional resets
    for (int n = 0; n < 2500; n++) begin
      rst_n    = ($urandom_range(0, 299) != 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, 31));
      wr_data  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
      rd_en    = ($urandom_range(0, 3) != 0);
      rd_addr1 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 31));
      rd_addr2 = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 31));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
